glb_stream_src: RTL and testbench
=================================

// Module: glb_stream_src
// PURPOSE
//   Synthesisable, parametrised global-buffer stream source feeding a ready/valid data port of the
//   memory-core/CGRA test fabric. Words are preloaded through a config write port; after a flush
//   pulse the block streams a programmable window (base, size, pass count) at up to 1 word/clk,
//   holding data stable under back-pressure, then raises done.
// PARAMETERS
//   DATA_WIDTH  16    width of each streamed word
//   DEPTH       1024  words of local storage (power of two)
//   ADDR_W      $clog2(DEPTH)  address width (derived, do not override)
//   CNT_W       ADDR_W+1       width of transfer-size and transfer-count fields
// PORTS
//   clk          in   1           clock, all logic on rising edge
//   rst          in   1           synchronous, active-high reset
//   flush        in   1           start/abort strobe; a stream starts on its falling edge
//   cfg_wr_en    in   1           preload write enable
//   cfg_wr_addr  in   ADDR_W      preload write address
//   cfg_wr_data  in   DATA_WIDTH  preload write data
//   cfg_base     in   ADDR_W      first word address of the window
//   cfg_tx_size  in   CNT_W       words per pass (0..DEPTH)
//   cfg_passes   in   8           number of passes over the window (0 treated as 1)
//   data         out  DATA_WIDTH  stream data
//   valid        out  1           stream valid
//   ready        in   1           stream ready from consumer
//   done         out  1           level: all transfers complete
//   busy         out  1           high in ARMED or STREAM
//   tx_count     out  CNT_W+8     accepted transfers since stream start
// BEHAVIOUR
//   - Reset: data=0, valid=0, done=0, busy=0, tx_count=0, FSM=IDLE. Storage array is NOT reset.
//   - flush is registered; rise = flush&~flush_q, fall = ~flush&flush_q (one-cycle detect latency).
//   - FSM: IDLE -rise-> ARMED; ARMED -fall-> STREAM; STREAM -last accept-> DONE; DONE -rise-> ARMED.
//     Any state -rise-> ARMED (abort): valid drops the next cycle, done cleared, pending word dropped.
//   - On entering STREAM, cfg_base/cfg_tx_size/cfg_passes are captured; later changes are ignored
//     until the next start. tx_count clears to 0 on entering ARMED.
//   - Transfer = valid&&ready at a rising edge; tx_count increments by 1 per transfer.
//   - While valid&&!ready, data and valid hold unchanged. valid never drops without a transfer,
//     except on abort or rst.
//   - Storage read is synchronous (1-cycle). A 2-entry output buffer (out reg + skid) sustains one
//     transfer per cycle with ready held high; no bubbles after the first word.
//   - Latency: fall detected at edge E -> first read issued at E+1 -> valid high after edge E+2.
//   - Address for word i of a pass = (cfg_base + i) mod DEPTH (wraps past DEPTH-1 to 0).
//   - After tx_size words, index returns to cfg_base for the next pass. Total transfers =
//     tx_size * max(passes,1); sequence is identical every pass.
//   - tx_size==0: STREAM moves to DONE on the next edge; valid never asserts; done=1, tx_count=0.
//   - done asserts in the cycle after the final transfer edge, simultaneously valid=0; holds until
//     rise or rst. busy = (state==ARMED||state==STREAM).
//   - cfg_wr_en permitted in any state. Same-cycle write and read of one address returns OLD data;
//     words read after the write see new data.
//   - tx_size > DEPTH is clamped to DEPTH.
//   - rst mid-stream: outputs return to reset values at the next edge; a new flush pulse is needed.
// TESTING
//   - Preload mem[i]=0x1000+i, base=0, size=32, passes=1, ready=1, pulse flush -> 32 transfers
//     0x1000..0x101F on consecutive cycles, valid 2 cycles after fall, done=1, tx_count=32.
//   - Same config, ready toggled 1/0 each cycle, plus random 5-cycle stalls -> data stable whenever
//     valid&&!ready, exact sequence 0x1000..0x101F, no duplicates or drops.
//   - base=1020, size=8, DEPTH=1024 -> words mem[1020..1023], mem[0..3]; done, tx_count=8.
//   - base=4, size=3, passes=3 -> mem[4],mem[5],mem[6] repeated 3x, tx_count=9; passes=0 -> 3 words.
//   - size=0 -> done after fall, valid never high, tx_count=0.
//   - Abort: flush pulse after 10 of 32 transfers -> valid low next cycle, done=0, tx_count=0 on
//     re-arm; on fall, restarts from mem[base]. rst mid-stream -> all outputs 0 next edge, preloaded
//     data intact on next run.

Source files
------------

// File: rtl/glb_stream_src.sv
// glb_stream_src: global-buffer stream source that streams a preloaded window over ready/valid
// Ports: clk/rst (sync, active-high); flush start/abort strobe (stream starts on its falling edge);
//   cfg_wr_* preload write port; cfg_base/cfg_tx_size/cfg_passes window, captured at stream start;
//   data/valid/ready output stream; done level after the last transfer; busy in ARMED or STREAM;
//   tx_count accepted transfers since the stream was armed.
module glb_stream_src #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int CNT_W      = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  cfg_wr_en,
    input  logic [ADDR_W-1:0]     cfg_wr_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wr_data,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [CNT_W-1:0]      cfg_tx_size,
    input  logic [7:0]            cfg_passes,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_W+7:0]      tx_count
);
    typedef enum logic [1:0] {IDLE, ARMED, STREAM, DONE} state_t;
    state_t state, state_d;
    logic flush_q, rise, fall, xfer, last, issue, rd_pend, skid_v, issue_end;
    logic [ADDR_W-1:0] base_q, addr;
    logic [CNT_W-1:0] size_q, idx;
    logic [7:0] passes_q, pass_cnt;
    logic [CNT_W+7:0] total;
    logic [1:0] occ;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data, skid;
    assign rise  = flush & ~flush_q;
    assign fall  = ~flush & flush_q;
    assign xfer  = valid & ready;
    assign total = (CNT_W+8)'(size_q) * (CNT_W+8)'(passes_q);
    assign last  = xfer && (tx_count + (CNT_W+8)'(1) == total);
    assign addr  = base_q + idx[ADDR_W-1:0];
    // words held in out reg + skid + read in flight, after this cycle's transfer; capped at 2
    assign occ   = 2'(valid) + 2'(skid_v) + 2'(rd_pend) - 2'(xfer);
    assign issue = state == STREAM && !issue_end && size_q != '0 && occ < 2'd2;
    assign done  = state == DONE;
    assign busy  = state == ARMED || state == STREAM;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = IDLE;
            ARMED:   state_d = fall ? STREAM : ARMED;
            STREAM:  state_d = (total == '0 || last) ? DONE : STREAM;
            default: state_d = DONE;
        endcase
        if (rise) state_d = ARMED;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            flush_q  <= 1'b0;
            tx_count <= '0;
        end else begin
            state    <= state_d;
            flush_q  <= flush;
            tx_count <= rise ? '0 : tx_count + (CNT_W+8)'(xfer);
        end
    end
    always_ff @(posedge clk) begin
        if (state == ARMED && state_d == STREAM) begin
            base_q    <= cfg_base;
            size_q    <= cfg_tx_size > CNT_W'(DEPTH) ? CNT_W'(DEPTH) : cfg_tx_size;
            passes_q  <= cfg_passes == 8'd0 ? 8'd1 : cfg_passes;
            idx       <= '0;
            pass_cnt  <= '0;
            issue_end <= 1'b0;
        end else if (issue) begin
            idx       <= idx + 1'b1 == size_q ? '0 : idx + 1'b1;
            pass_cnt  <= idx + 1'b1 == size_q ? pass_cnt + 1'b1 : pass_cnt;
            issue_end <= idx + 1'b1 == size_q && pass_cnt + 1'b1 == passes_q;
        end
    end
    always_ff @(posedge clk) begin
        if (cfg_wr_en) mem[cfg_wr_addr] <= cfg_wr_data;
        if (issue) rd_data <= mem[addr];
    end
    // read data lands in the out reg when it is free, otherwise in the skid entry
    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            skid_v  <= 1'b0;
            rd_pend <= 1'b0;
        end else if (state_d != STREAM) begin
            valid   <= 1'b0;
            skid_v  <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= issue;
            if (!valid || ready) begin
                valid  <= skid_v || rd_pend;
                data   <= skid_v ? skid : (rd_pend ? rd_data : data);
                skid_v <= skid_v && rd_pend;
                skid   <= skid_v && rd_pend ? rd_data : skid;
            end else if (rd_pend) begin
                skid   <= rd_data;
                skid_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_glb_stream_src.sv
// tb_glb_stream_src: scoreboard bench for glb_stream_src
module tb_glb_stream_src;
    localparam int DEPTH = 1024;
    logic clk = 1'b0, rst, flush, cfg_wr_en, valid, ready, done, busy;
    logic [9:0] cfg_wr_addr, cfg_base;
    logic [15:0] cfg_wr_data, data;
    logic [10:0] cfg_tx_size;
    logic [7:0] cfg_passes;
    logic [18:0] tx_count;
    logic [15:0] tb_mem [DEPTH];
    logic [15:0] q [$];
    logic [15:0] hold_data;
    int checks = 0, errors = 0, stall = 0;
    bit hold_prev = 0, saw_valid = 0;
    glb_stream_src dut (
        .clk(clk), .rst(rst), .flush(flush), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .cfg_base(cfg_base), .cfg_tx_size(cfg_tx_size),
        .cfg_passes(cfg_passes), .data(data), .valid(valid), .ready(ready), .done(done),
        .busy(busy), .tx_count(tx_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (valid) saw_valid = 1;
        if (hold_prev) begin
            chk("hold_valid", {31'd0, valid}, 32'd1);
            chk("hold_data", {16'd0, data}, {16'd0, hold_data});
        end
        hold_prev = valid && !ready && !flush && !rst;
        hold_data = data;
        if (valid && ready && !flush && !rst) begin
            if (q.size() == 0) chk("extra_word_queue_size", 32'(q.size()), 32'd1);
            else chk("data", {16'd0, data}, {16'd0, q.pop_front()});
        end
    end
    task automatic push(input int base, input int size, input int passes);
        int s = size > DEPTH ? DEPTH : size;
        int p = passes == 0 ? 1 : passes;
        for (int k = 0; k < p; k++)
            for (int i = 0; i < s; i++) q.push_back(tb_mem[(base + i) % DEPTH]);
    endtask
    task automatic start(input int base, input int size, input int passes);
        cfg_base = 10'(base);
        cfg_tx_size = 11'(size);
        cfg_passes = 8'(passes);
        push(base, size, passes);
        flush = 1;
        tick();
        flush = 0;
    endtask
    task automatic wait_done(input int rmode);
        int n = 0;
        while (!done && n < 3000) begin
            if (rmode == 0) ready = 1;
            else if (stall > 0) begin ready = 0; stall--; end
            else if ($urandom_range(0, 19) == 0) begin ready = 0; stall = 4; end
            else ready = ~ready;
            tick();
            n++;
        end
        ready = 0;
        chk("done_in_time", {31'd0, done}, 32'd1);
        chk("valid_at_done", {31'd0, valid}, 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask
    task automatic run(input int base, input int size, input int passes, input int rmode);
        int s = size > DEPTH ? DEPTH : size;
        start(base, size, passes);
        tick();
        cfg_base = 10'h155;
        cfg_tx_size = 11'd5;
        cfg_passes = 8'd7;
        wait_done(rmode);
        chk("tx_count", {13'd0, tx_count}, 32'(s * (passes == 0 ? 1 : passes)));
    endtask
    initial begin
        rst = 1; flush = 0; cfg_wr_en = 0; cfg_wr_addr = 0; cfg_wr_data = 0;
        cfg_base = 0; cfg_tx_size = 0; cfg_passes = 0; ready = 0;
        repeat (2) tick();
        chk("rst_data", {16'd0, data}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_count", {13'd0, tx_count}, 32'd0);
        rst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cfg_wr_en = 1;
            cfg_wr_addr = 10'(i);
            cfg_wr_data = 16'(16'h1000 + i);
            tb_mem[i] = 16'(16'h1000 + i);
            tick();
        end
        cfg_wr_en = 0;
        ready = 1;
        start(0, 32, 1);
        tick();
        chk("lat_e_valid", {31'd0, valid}, 32'd0);
        chk("lat_e_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("lat_e1_valid", {31'd0, valid}, 32'd0);
        tick();
        chk("lat_e2_valid", {31'd0, valid}, 32'd1);
        chk("lat_e2_data", {16'd0, data}, 32'h1000);
        wait_done(0);
        chk("t1_tx_count", {13'd0, tx_count}, 32'd32);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        run(0, 32, 1, 1);
        run(1020, 8, 1, 0);
        run(4, 3, 3, 0);
        run(4, 3, 0, 0);
        saw_valid = 0;
        run(0, 0, 1, 0);
        chk("size0_no_valid", {31'd0, saw_valid}, 32'd0);
        run(0, 1100, 1, 0);
        ready = 1;
        start(0, 32, 1);
        for (int n = 0; n < 200 && tx_count != 19'd10; n++) tick();
        chk("abort_reach_10", {13'd0, tx_count}, 32'd10);
        ready = 0;
        flush = 1;
        tick();
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_tx_count", {13'd0, tx_count}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        q.delete();
        push(0, 32, 1);
        flush = 0;
        wait_done(0);
        chk("abort_rerun_tx", {13'd0, tx_count}, 32'd32);
        ready = 1;
        start(0, 32, 1);
        repeat (15) tick();
        ready = 0;
        rst = 1;
        tick();
        chk("mid_rst_data", {16'd0, data}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_tx", {13'd0, tx_count}, 32'd0);
        rst = 0;
        q.delete();
        tick();
        run(0, 32, 1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
